// File: rtl/pll_reset_seq_if.sv
// Purpose : bundles the PLL-side and reset-tree-side signals of pll_reset_seq.
// Latency : none, wiring only.
// Backpressure: none; level signals only, no handshake.
// Ports (master = sequencer view):
//   pll_locked      in   raw PLL LOCK, asynchronous to clk
//   force_reset     in   single-cycle request to restart the whole sequence
//   pll_rst         out  PLL RST drive
//   domain_rst      out  per-domain active-high resets, bit k released k-th
//   ready           out  high while the domains are running
//   fail            out  sticky failure flag
//   retry_count     out  retries used in the current bring-up
//   lock_loss_count out  saturating count of lock losses after release began
interface pll_reset_seq_if #(
  parameter int N_DOMAINS   = 4,
  parameter int MAX_RETRIES = 3
);
  localparam int RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  logic                 pll_locked;
  logic                 force_reset;
  logic                 pll_rst;
  logic [N_DOMAINS-1:0] domain_rst;
  logic                 ready;
  logic                 fail;
  logic [RC_W-1:0]      retry_count;
  logic [7:0]           lock_loss_count;

  modport master (
    input  pll_locked, force_reset,
    output pll_rst, domain_rst, ready, fail, retry_count, lock_loss_count
  );

  modport slave (
    output pll_locked, force_reset,
    input  pll_rst, domain_rst, ready, fail, retry_count, lock_loss_count
  );
endinterface

// File: rtl/pll_reset_seq.sv
// Purpose : PLL supervisor and staggered domain reset sequencer with lock qualification and retry.
// Latency : outputs registered; a pll_locked change reaches the outputs 3 cycles later (2 sync + 1 register).
// Backpressure: none; force_reset is a one-cycle pulse, always accepted.
// Ports:
//   i_clk  reference clock (also the PLL input clock)
//   i_rst  synchronous active-high reset
//   bus    pll_reset_seq_if.master: pll_locked/force_reset in, PLL and domain resets plus status out
module pll_reset_seq #(
  parameter int N_DOMAINS           = 4,
  parameter int PLL_RST_CYCLES      = 32,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  pll_reset_seq_if.master   bus
);

  localparam int RC_W     = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int REL_LAST = (N_DOMAINS - 1) * STAGGER_CYCLES;

  // One shared counter serves every state, so size it for the longest phase.
  localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CD = (LOCK_TIMEOUT_CYCLES > REL_LAST) ? LOCK_TIMEOUT_CYCLES : REL_LAST;
  localparam int MAX_C  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W  = $clog2(MAX_C + 1);

  // Terminal counts: a phase of L cycles ends on the cycle the counter holds L-1.
  localparam logic [CNT_W-1:0] PLL_END    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_END     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_END = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_END    = CNT_W'(REL_LAST);
  localparam logic [RC_W-1:0]  RETRY_MAX  = RC_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [RC_W-1:0]      r_retry, w_retry_nxt;
  logic [7:0]           r_llc, w_llc_nxt;

  logic                 r_lock_meta, r_lock_sync;
  logic                 w_locked_s;

  logic                 r_pll_rst, w_pll_rst_nxt;
  logic [N_DOMAINS-1:0] r_dom, w_dom_nxt;
  logic                 r_ready, w_ready_nxt;
  logic                 r_fail, w_fail_nxt;

  assign w_locked_s = r_lock_sync;

  // State register, counters, synchroniser and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_PLL_RST;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_llc       <= '0;
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
      r_pll_rst   <= 1'b1;
      r_dom       <= '1;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_retry     <= w_retry_nxt;
      r_llc       <= w_llc_nxt;
      r_lock_meta <= bus.pll_locked;
      r_lock_sync <= r_lock_meta;
      r_pll_rst   <= w_pll_rst_nxt;
      r_dom       <= w_dom_nxt;
      r_ready     <= w_ready_nxt;
      r_fail      <= w_fail_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_retry_nxt = r_retry;
    w_llc_nxt   = r_llc;

    case (r_state)
      S_PLL_RST: begin
        if (r_cnt == PLL_END) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT_LOCK: begin
        // Lock is checked first so it wins over a coincident timeout.
        if (w_locked_s) begin
          w_state_nxt = S_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TO_END) begin
          w_cnt_nxt = '0;
          if (r_retry < RETRY_MAX) begin
            w_retry_nxt = r_retry + RC_W'(1);
            w_state_nxt = S_PLL_RST;
          end else begin
            w_state_nxt = S_FAIL;
          end
        end
      end
      S_STABLE: begin
        // A glitch before release is not a lock loss: just wait again, no retry spent.
        if (!w_locked_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STABLE_END) begin
          w_state_nxt = S_RELEASE;
          w_cnt_nxt   = '0;
        end
      end
      S_RELEASE: begin
        if (!w_locked_s) begin
          w_state_nxt = S_PLL_RST;
          w_cnt_nxt   = '0;
          w_retry_nxt = '0;
          if (r_llc != 8'hFF) w_llc_nxt = r_llc + 8'd1;
        end else if (r_cnt == REL_END) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
          w_retry_nxt = '0;
        end
      end
      S_RUN: begin
        w_cnt_nxt = '0;
        if (!w_locked_s) begin
          w_state_nxt = S_PLL_RST;
          w_retry_nxt = '0;
          if (r_llc != 8'hFF) w_llc_nxt = r_llc + 8'd1;
        end
      end
      S_FAIL: begin
        w_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt = S_PLL_RST;
        w_cnt_nxt   = '0;
      end
    endcase

    // Restart request overrides everything above, including a lock-loss count.
    if (bus.force_reset) begin
      w_state_nxt = S_PLL_RST;
      w_cnt_nxt   = '0;
      w_retry_nxt = '0;
      w_llc_nxt   = r_llc;
    end
  end

  // Output decode from the next state, so every output comes straight off a flop.
  always_comb begin
    w_pll_rst_nxt = (w_state_nxt == S_PLL_RST);
    w_ready_nxt   = (w_state_nxt == S_RUN);
    w_fail_nxt    = (w_state_nxt == S_FAIL);
    w_dom_nxt     = '1;
    if (w_state_nxt == S_RUN) begin
      w_dom_nxt = '0;
    end else if (w_state_nxt == S_RELEASE) begin
      // Bit k drops once the stagger counter reaches k*STAGGER_CYCLES and stays low.
      for (int k = 0; k < N_DOMAINS; k++) begin
        if (w_cnt_nxt >= CNT_W'(k * STAGGER_CYCLES)) w_dom_nxt[k] = 1'b0;
      end
    end
  end

  assign bus.pll_rst         = r_pll_rst;
  assign bus.domain_rst      = r_dom;
  assign bus.ready           = r_ready;
  assign bus.fail            = r_fail;
  assign bus.retry_count     = r_retry;
  assign bus.lock_loss_count = r_llc;

endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Parametrised PLL supervisor and reset sequencer for ECP5 designs.
- Drives the PLL reset input and qualifies the PLL lock signal over a stability window.
- Releases N synchronous domain resets in staggered index order.
- On lock loss, re-asserts all domain resets and restarts the PLL. Failed lock attempts are retried up to a limit, after which the block reports a sticky failure.
- Sits between the board-clock PLL instance and the SoC reset tree.

Parameters:
N_DOMAINS, 4, number of domain_rst outputs (>=1)
PLL_RST_CYCLES, 32, clk cycles pll_rst is held high per attempt (>=1)
LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before release (>=1)
STAGGER_CYCLES, 16, clk cycles between successive domain releases (>=1)
LOCK_TIMEOUT_CYCLES, 65536, cycles allowed in WAIT_LOCK before the attempt counts as failed (>=1)
MAX_RETRIES, 3, extra PLL reset attempts before FAIL (>=0)

Ports:
clk  in  1  reference clock (25 MHz board clock, also the PLL CLKI)
rst  in  1  synchronous, active-high reset
pll_locked  in  1  PLL LOCK output; asynchronous to clk, passes through a 2-flop synchroniser inside the block
force_reset  in  1  single-cycle request to restart the whole sequence
pll_rst  out  1  PLL RST drive
domain_rst  out  N_DOMAINS  per-domain reset, active-high; bit k is released k-th
ready  out  1  high while in RUN
fail  out  1  sticky failure flag
retry_count  out  clog2(MAX_RETRIES+1) (min 1)  retries used in the current bring-up
lock_loss_count  out  8  lock losses seen after release began; saturates at 255

Behaviour:
- All outputs are registered.
- locked_s is pll_locked after the 2-flop synchroniser. A pll_locked edge at cycle t is visible in locked_s at t+2.
- Reset (rst=1):
  - state=PLL_RST, pll_rst=1, domain_rst=all 1, ready=0, fail=0.
  - retry_count=0, lock_loss_count=0, internal counters=0.
  - rst mid-operation behaves identically.
- States:
  - PLL_RST:
    - pll_rst=1, domain_rst=all 1.
    - After PLL_RST_CYCLES cycles in this state -> WAIT_LOCK, with pll_rst=0 from the first WAIT_LOCK cycle.
  - WAIT_LOCK:
    - Timeout counter runs from 0.
    - locked_s=1 -> STABLE.
    - Counter reaches LOCK_TIMEOUT_CYCLES:
      - if retry_count<MAX_RETRIES: retry_count++, -> PLL_RST.
      - otherwise -> FAIL.
  - STABLE:
    - Counts consecutive locked_s=1 cycles.
    - Count reaches LOCK_STABLE_CYCLES -> RELEASE.
    - locked_s=0 -> WAIT_LOCK with the timeout counter restarted. No retry increment and no lock_loss_count increment.
  - RELEASE:
    - The stagger counter starts at 0 on entry.
    - domain_rst[k] deasserts on the cycle where counter = k*STAGGER_CYCLES. A released bit stays low.
    - When the cycle that deasserts the last bit completes -> RUN.
    - ready=1 from the first RUN cycle, which is the cycle after the last bit deasserts.
  - RUN:
    - ready=1, domain_rst=all 0, pll_rst=0.
    - retry_count clears to 0 on RUN entry.
  - FAIL:
    - pll_rst=0, domain_rst=all 1, ready=0, fail=1.
    - Leaves only on rst or force_reset.
- Lock loss (locked_s=0 in RELEASE or RUN):
  - Next cycle: domain_rst=all 1, ready=0, pll_rst=1, state=PLL_RST.
  - lock_loss_count increments, saturating at 255.
  - retry_count clears to 0.
- force_reset=1 in any state:
  - Next cycle: state=PLL_RST, pll_rst=1, domain_rst=all 1, ready=0, fail=0, retry_count=0.
  - lock_loss_count is unchanged.
  - If force_reset coincides with lock loss, force_reset wins and lock_loss_count does not increment.
  - force_reset while already in PLL_RST restarts the PLL_RST hold count.
- Simultaneous events:
  - rst beats force_reset.
  - In WAIT_LOCK, timeout and locked_s=1 on the same cycle -> STABLE (lock wins).
- N_DOMAINS=1: RELEASE lasts 1 cycle.
- Invariant: ready=1 implies domain_rst=0 and pll_rst=0. fail=1 implies ready=0.

Test Plan:
Bench parameters for all scenarios: N_DOMAINS=3, PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, STAGGER_CYCLES=2, LOCK_TIMEOUT_CYCLES=20, MAX_RETRIES=2.
- Clean bring-up: pll_locked=1 from cycle 0 after rst -> pll_rst high 4 cycles; domain_rst bits 0/1/2 fall at RELEASE+0/+2/+4; ready=1 one cycle after bit 2 falls; retry_count=0.
- Lock glitch in STABLE: locked pulses low 1 cycle at STABLE cycle 5 -> returns to WAIT_LOCK, no domain release until 8 fresh stable cycles; lock_loss_count=0, retry_count=0.
- Never locks: pll_locked=0 -> three pll_rst pulses of 4 cycles each, retry_count steps 1,2, then fail=1, domain_rst=3'b111, pll_rst=0; later lock does not leave FAIL; force_reset clears fail and restarts.
- Lock loss in RUN: drop pll_locked -> domain_rst=3'b111, ready=0 by 3 cycles after the drop (2 sync + 1 register); lock_loss_count=1; full resequence on relock.
- Lock loss mid-RELEASE after bit 0 released: all bits re-asserted, lock_loss_count increments; repeated 300 times, lock_loss_count saturates at 255.
- force_reset same cycle as lock loss in RUN: lock_loss_count unchanged, pll_rst=1 next cycle; rst asserted mid-RELEASE -> all outputs at reset values next cycle.
